counter_arbiter_ctrl: RTL and testbench



---
 rtl/counter_arbiter_ctrl.sv | 96 +++++++++
 tb/tb_counter_arbiter_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/counter_arbiter_ctrl.sv
// rtl/counter_arbiter_ctrl.sv - round-robin arbiter sequencing timed runs of one shared counter
module counter_arbiter_ctrl #(
   parameter int CNT_WIDTH = 4,
   parameter int NREQ      = 4
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [NREQ-1:0]           Req,
   input  logic [NREQ*CNT_WIDTH-1:0] Len,
   input  logic [CNT_WIDTH-1:0]      CntVal,
   output logic [NREQ-1:0]           Grant,
   output logic [NREQ-1:0]           Done,
   output logic                      Busy,
   output logic                      CntEn,
   output logic                      CntClr_n
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

   state_t               state, state_nxt;
   logic [IW-1:0]        winner, ptr, pick;
   logic [CNT_WIDTH-1:0] target;
   logic                 found;
   logic [NREQ-1:0]      gvec;
   int unsigned          cand;

   // First set request searching upward from the last winner, wrapping around.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = (32'(ptr) + 32'(k)) % 32'(NREQ);
         if (!found && Req[cand[IW-1:0]]) begin
            found = 1'b1;
            pick  = cand[IW-1:0];
         end
      end
   end

   assign gvec = NREQ'(1) << winner;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state  <= IDLE;
         winner <= '0;
         target <= '0;
         ptr    <= IW'(NREQ - 1);
      end else begin
         state <= state_nxt;
         if (state == IDLE && found) begin
            winner <= pick;
            target <= Len[pick*CNT_WIDTH +: CNT_WIDTH];
         end
         if (state == DONE)
            ptr <= winner;
      end
   end

   always_comb begin
      state_nxt = state;
      Grant     = '0;
      Done      = '0;
      Busy      = 1'b1;
      CntEn     = 1'b0;
      CntClr_n  = 1'b1;
      case (state)
         IDLE: begin
            Busy = 1'b0;
            if (found)
               state_nxt = CLEAR;
         end
         CLEAR: begin
            Grant     = gvec;
            CntClr_n  = 1'b0;
            state_nxt = (target == '0) ? DONE : RUN;
         end
         RUN: begin
            Grant = gvec;
            CntEn = 1'b1;
            // Leaving when the counter shows target-1 lets this last enable land it on target.
            if (CntVal >= target - CNT_WIDTH'(1))
               state_nxt = DONE;
         end
         DONE: begin
            Grant     = gvec;
            Done      = gvec;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_counter_arbiter_ctrl.sv
// tb/tb_counter_arbiter_ctrl.sv - directed-vector bench for counter_arbiter_ctrl with a behavioural counter
module tb_counter_arbiter_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [3:0]  Req = '0;
   logic [15:0] Len = '0;
   logic [3:0]  CntVal;
   logic [3:0]  Grant, Done;
   logic        Busy, CntEn, CntClr_n;
   logic [3:0]  cnt = '0;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [15:0] len;
      logic [3:0]  grant;
      int          en;
      int          done_cyc;
      logic [3:0]  cv;
   } vec_t;

   vec_t tv[11];

   counter_arbiter_ctrl #(.CNT_WIDTH(4), .NREQ(4)) dut (
      .Clk(Clk), .Reset(Reset), .Req(Req), .Len(Len), .CntVal(CntVal),
      .Grant(Grant), .Done(Done), .Busy(Busy), .CntEn(CntEn), .CntClr_n(CntClr_n)
   );

   always #5 Clk = ~Clk;

   // Shared counter: async active-low clear, count enable.
   always @(posedge Clk or negedge CntClr_n) begin
      if (!CntClr_n) cnt <= '0;
      else if (CntEn) cnt <= cnt + 4'd1;
   end
   assign CntVal = cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic apply_reset();
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   // Entered at a falling edge with the DUT idle; returns at the falling edge of the next idle cycle.
   task automatic do_op(input int n);
      int         cyc, en, dc;
      logic [3:0] cv, dv;
      Req = tv[n].req;
      Len = tv[n].len;
      chk($sformatf("v%0d idle_busy", n), 32'(Busy), 0);
      en = 0; dc = -1; cyc = 0; cv = 'x; dv = 'x;
      while (dc < 0 && cyc < 40) begin
         @(negedge Clk);
         cyc++;
         if (cyc == 1) chk($sformatf("v%0d clr_low_c1", n), 32'(CntClr_n), 0);
         chk($sformatf("v%0d grant_c%0d", n, cyc), 32'(Grant), 32'(tv[n].grant));
         if (CntEn) en++;
         if (Done != '0) begin
            dc = cyc; dv = Done; cv = cnt;
         end
      end
      chk($sformatf("v%0d done_cycle", n), 32'(dc), 32'(tv[n].done_cyc));
      chk($sformatf("v%0d done_vec", n), 32'(dv), 32'(tv[n].grant));
      chk($sformatf("v%0d en_cycles", n), 32'(en), 32'(tv[n].en));
      chk($sformatf("v%0d cntval_at_done", n), 32'(cv), 32'(tv[n].cv));
      @(negedge Clk);
      chk($sformatf("v%0d busy_after", n), 32'(Busy), 0);
      chk($sformatf("v%0d grant_after", n), 32'(Grant), 0);
      Req = '0;
   endtask

   initial begin
      //        rst   req      len {L3,L2,L1,L0}       grant    en  done cv
      tv[0]  = '{1'b1, 4'b0001, 16'h0005, 4'b0001,  5,  7, 4'd5};
      tv[1]  = '{1'b1, 4'b0101, 16'h0203, 4'b0001,  3,  5, 4'd3};
      tv[2]  = '{1'b0, 4'b0101, 16'h0203, 4'b0100,  2,  4, 4'd2};
      tv[3]  = '{1'b1, 4'b1111, 16'h1111, 4'b0001,  1,  3, 4'd1};
      tv[4]  = '{1'b0, 4'b1111, 16'h1111, 4'b0010,  1,  3, 4'd1};
      tv[5]  = '{1'b0, 4'b1111, 16'h1111, 4'b0100,  1,  3, 4'd1};
      tv[6]  = '{1'b0, 4'b1111, 16'h1111, 4'b1000,  1,  3, 4'd1};
      tv[7]  = '{1'b0, 4'b1111, 16'h1111, 4'b0001,  1,  3, 4'd1};
      tv[8]  = '{1'b0, 4'b0010, 16'h0000, 4'b0010,  0,  2, 4'd0};
      tv[9]  = '{1'b0, 4'b0001, 16'h000F, 4'b0001, 15, 17, 4'd15};
      tv[10] = '{1'b0, 4'b1111, 16'h2222, 4'b0001,  2,  4, 4'd2};

      repeat (2) @(negedge Clk);
      chk("reset_grant", 32'(Grant), 0);
      chk("reset_done", 32'(Done), 0);
      chk("reset_busy", 32'(Busy), 0);
      chk("reset_cnten", 32'(CntEn), 0);
      chk("reset_clr_n", 32'(CntClr_n), 1);
      Reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         if (tv[i].rst) apply_reset();
         do_op(i);
      end

      // Reset pulsed in the 4th RUN cycle of a length-10 run.
      apply_reset();
      Req = 4'b0001;
      Len = 16'h000A;
      for (int c = 1; c <= 5; c++) begin
         @(negedge Clk);
         if (c == 5) begin
            chk("midrst_cnten_before", 32'(CntEn), 1);
            chk("midrst_grant_before", 32'(Grant), 32'h1);
         end
      end
      Reset = 1'b1;
      #1;
      chk("midrst_grant", 32'(Grant), 0);
      chk("midrst_cnten", 32'(CntEn), 0);
      chk("midrst_busy", 32'(Busy), 0);
      chk("midrst_clr_n", 32'(CntClr_n), 1);
      chk("midrst_done", 32'(Done), 0);
      @(negedge Clk);
      Reset = 1'b0;
      Req = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         chk($sformatf("midrst_no_done_%0d", c), 32'(Done), 0);
      end
      do_op(10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
